// File: rtl/ser_rx.sv
// ser_rx: LSB-first serial receiver, 2-flop input sync, valid/ready output.
// Optional even-parity bit and perr output when SER_RX_PARITY_EN is defined.
module ser_rx #(
  parameter int W   = 8,
  parameter int DIV = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rxd,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         ferr,
`ifdef SER_RX_PARITY_EN
  output logic         perr,
`endif
  output logic         ovr
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] HALF = CW'(DIV/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [IW-1:0] LAST = IW'(W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SER_RX_PARITY_EN
    PAR,
`endif
    STOP,
    BRK
  } state_t;

  state_t        state_q;
  logic          s1_q;
  logic          rxs_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  sh_q;
  logic [W-1:0]  sh_d;
  logic [W-1:0]  data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          ovr_q;
  logic          par_ok;
  logic          tick;
  logic          hs;

  assign tick = (cnt_q == '0);
  assign hs   = valid_q && ready;
  // shift toward bit 0, new sample enters at the MSB
  assign sh_d = (sh_q >> 1) | (W'(rxs_q) << (W - 1));

`ifdef SER_RX_PARITY_EN
  logic pbad_q;
  logic perr_q;
  assign par_ok = !pbad_q;
  assign perr   = perr_q;
`else
  assign par_ok = 1'b1;
`endif

  // two-flop synchronizer, idle-high after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      s1_q  <= rxd;
      rxs_q <= s1_q;
    end
  end

  // frame FSM, bit timer, shift register and output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SER_RX_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
`ifdef SER_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (hs) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (state_q != IDLE && state_q != BRK && !tick)
        cnt_q <= cnt_q - 1'b1;
      unique case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            state_q <= START;
            cnt_q   <= HALF;
          end
        end
        START: begin
          if (tick) begin
            if (!rxs_q) begin
              state_q <= DATA;
              cnt_q   <= FULL;
              idx_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            sh_q  <= sh_d;
            cnt_q <= FULL;
            if (idx_q == LAST) begin
`ifdef SER_RX_PARITY_EN
              state_q <= PAR;
`else
              state_q <= STOP;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
`ifdef SER_RX_PARITY_EN
        PAR: begin
          if (tick) begin
            pbad_q  <= (^sh_q) ^ rxs_q;
            perr_q  <= (^sh_q) ^ rxs_q;
            cnt_q   <= FULL;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (rxs_q) begin
              state_q <= IDLE;
              if (par_ok) begin
                if (!valid_q || ready) begin
                  data_q  <= sh_q;
                  valid_q <= 1'b1;
                end else begin
                  ovr_q <= 1'b1;
                end
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BRK;
            end
          end
        end
        BRK: begin
          if (rxs_q)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign ferr  = ferr_q;
  assign ovr   = ovr_q;

endmodule

// File: tb/tb_ser_rx.sv
// tb_ser_rx: directed frames for ser_rx (W=8, DIV=4).
// Table of single frames plus hand sequences for overrun, break, reset.
module tb_ser_rx;

  localparam int W   = 8;
  localparam int DIV = 4;
`ifdef SER_RX_PARITY_EN
  localparam int LAT = 2 + 2 + 36 + 1 + DIV;
`else
  localparam int LAT = 2 + 2 + 36 + 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rxd = 1'b1;
  logic         ready = 1'b0;
  logic [W-1:0] data;
  logic         valid;
  logic         ferr;
  logic         ovr;
`ifdef SER_RX_PARITY_EN
  logic         perr;
`endif

  ser_rx #(.W(W), .DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .ready (ready),
    .data  (data),
    .valid (valid),
    .ferr  (ferr),
`ifdef SER_RX_PARITY_EN
    .perr  (perr),
`endif
    .ovr   (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int       n_pass = 0;
  int       n_tot  = 0;
  int       vcnt, fcnt, pcnt, rise_cyc, start_cyc;
  logic [W-1:0] cap;
  logic     vprev = 1'b0;

  always @(negedge clk) begin
    if (valid && !vprev) begin
      rise_cyc = cyc;
      cap      = data;
    end
    if (valid) vcnt++;
    if (ferr) fcnt++;
`ifdef SER_RX_PARITY_EN
    if (perr) pcnt++;
`endif
    vprev = valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: act=%0d req=%0d", name, act, req);
  endtask

  task automatic clear_mon();
    vcnt = 0;
    fcnt = 0;
    pcnt = 0;
    rise_cyc = -1;
    cap = '0;
  endtask

  task automatic drive(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic stop,
                            input logic par);
    start_cyc = cyc;
    drive(1'b0, DIV);
    for (int i = 0; i < W; i++) drive(w[i], DIV);
`ifdef SER_RX_PARITY_EN
    drive(par, DIV);
`else
    if (par === 1'bz) $display("unreachable");
`endif
    drive(stop, DIV);
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] w;
    logic         stop;
    logic [W-1:0] exp_data;
    int           exp_v;
    int           exp_f;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{8'h5A, 1'b1, 8'h5A, 1, 0};
    vt[1] = '{8'h11, 1'b1, 8'h11, 1, 0};
    vt[2] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vt[3] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vt[4] = '{8'h3C, 1'b0, 8'h00, 0, 1};
    vt[5] = '{8'h80, 1'b1, 8'h80, 1, 0};

    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovr", ovr, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 4);

    // one-clock glitch on idle line
    clear_mon();
    drive(1'b0, 1);
    drive(1'b1, 12);
    check("glitch_valid", vcnt, 0);
    check("glitch_ferr", fcnt, 0);

    // table of single frames, ready held high
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      send_frame(vt[i].w, vt[i].stop, ^vt[i].w);
      drive(1'b1, 8);
      check($sformatf("vec%0d_data", i), cap, vt[i].exp_data);
      check($sformatf("vec%0d_vcyc", i), vcnt, vt[i].exp_v);
      check($sformatf("vec%0d_ferr", i), fcnt, vt[i].exp_f);
      if (vt[i].exp_v == 1)
        check($sformatf("vec%0d_lat", i), rise_cyc - start_cyc, LAT);
    end

    // bad stop then line held low: no spurious frame
    clear_mon();
    send_frame(8'hC3, 1'b0, ^8'hC3);
    drive(1'b0, 20);
    drive(1'b1, 6);
    check("brk_ferr", fcnt, 1);
    check("brk_valid", vcnt, 0);
    clear_mon();
    send_frame(8'h11, 1'b1, ^8'h11);
    drive(1'b1, 8);
    check("brk_next_data", cap, 8'h11);
    check("brk_next_vcyc", vcnt, 1);

    // overrun with ready low
    ready = 1'b0;
    send_frame(8'h01, 1'b1, ^8'h01);
    drive(1'b1, 4);
    send_frame(8'h02, 1'b1, ^8'h02);
    drive(1'b1, 8);
    check("ovr_valid", valid, 1);
    check("ovr_data", data, 8'h01);
    check("ovr_flag", ovr, 1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("ack_valid", valid, 0);
    check("ack_ovr", ovr, 0);
    send_frame(8'h03, 1'b1, ^8'h03);
    drive(1'b1, 8);
    check("post_valid", valid, 1);
    check("post_data", data, 8'h03);
    check("post_ovr", ovr, 0);

    // fill again, then reset mid-DATA
    send_frame(8'h04, 1'b1, ^8'h04);
    drive(1'b1, 8);
    check("pre_rst_ovr", ovr, 1);
    drive(1'b0, DIV);
    drive(1'b1, 3 * DIV);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_data", data, 0);
    check("mid_rst_ferr", ferr, 0);
    check("mid_rst_ovr", ovr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 8);
    ready = 1'b1;
    clear_mon();
    send_frame(8'h81, 1'b1, ^8'h81);
    drive(1'b1, 8);
    check("after_rst_data", cap, 8'h81);
    check("after_rst_vcyc", vcnt, 1);
    check("after_rst_ferr", fcnt, 0);

`ifdef SER_RX_PARITY_EN
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    drive(1'b1, 8);
    check("par_ok_data", cap, 8'h07);
    check("par_ok_vcyc", vcnt, 1);
    check("par_ok_perr", pcnt, 0);
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0);
    drive(1'b1, 8);
    check("par_bad_vcyc", vcnt, 0);
    check("par_bad_perr", pcnt, 1);
    check("par_bad_ferr", fcnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
